// File: rtl/aq_djpeg_mcu_sched.sv
// MCU scheduler: walks the MCU grid and issues one block tag per request, throttled by buffer
// fullness and an outstanding-block cap. Optional stall counter under AQ_DJPEG_MCU_SCHED_PERF_EN.
module aq_djpeg_mcu_sched #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        ProcessInit,
    input  logic [2:0]  JpegComp,
    input  logic [1:0]  SubSamplingW,
    input  logic [1:0]  SubSamplingH,
    input  logic [15:0] ImageWidth,
    input  logic [15:0] ImageHeight,
    input  logic        BlockReq,
    output logic        BlockAck,
    output logic [2:0]  BlockColor,
    output logic [11:0] McuX,
    output logic [11:0] McuY,
    output logic [11:0] McuBlockWidth,
    input  logic        BlockDone,
    input  logic        DataInFull,
    output logic        Busy,
    output logic        FrameEnd,
    output logic        ConfigError,
    output logic        SeqError
`ifdef AQ_DJPEG_MCU_SCHED_PERF_EN
    ,
    output logic [31:0] StallCycles
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [2:0] OUT_MAX = 3'(MAX_OUTSTANDING);

    state_t      r_state;
    logic        r_cfg_ok;
    logic        r_gray;
    logic        r_sw2;
    logic        r_sh2;
    logic [15:0] r_width;
    logic [15:0] r_height;
    logic [11:0] r_rows;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic [2:0]  r_seq;
    logic [2:0]  r_outst;

    logic        w_cfg_ok;
    logic [11:0] w_mcu_cols;
    logic [11:0] w_mcu_rows;
    logic [2:0]  w_seq_last;
    logic        w_cap_ok;
    logic        w_grant;
    logic        w_done_ok;
    logic        w_x_last;
    logic        w_last;

    // Component code for a position in the per-MCU sequence of the latched mode
    function automatic logic [2:0] seq_color(input logic gray, input logic sw2,
                                             input logic sh2, input logic [2:0] idx);
        if (gray)
            return 3'd0;
        if (sw2 && sh2)
            return idx;
        if (idx == 3'd0)
            return 3'd0;
        if (sw2 || sh2) begin
            if (idx == 3'd1)
                return sw2 ? 3'd1 : 3'd2;
            return idx + 3'd2;
        end
        return idx + 3'd3;
    endfunction

    always_comb begin
        w_cfg_ok = ((JpegComp == 3'd1) || (JpegComp == 3'd3)) &&
                   ((SubSamplingW == 2'd1) || (SubSamplingW == 2'd2)) &&
                   ((SubSamplingH == 2'd1) || (SubSamplingH == 2'd2)) &&
                   (ImageWidth != 16'd0) && (ImageWidth <= 16'd32760) &&
                   (ImageHeight != 16'd0) && (ImageHeight <= 16'd32760);
        // Sum cannot exceed 32760+15, so 16 bits hold it before the shift
        w_mcu_cols = 12'((r_width + (r_sw2 ? 16'd15 : 16'd7)) >> (r_sw2 ? 4 : 3));
        w_mcu_rows = 12'((r_height + (r_sh2 ? 16'd15 : 16'd7)) >> (r_sh2 ? 4 : 3));
        if (r_gray)
            w_seq_last = 3'd0;
        else if (r_sw2 && r_sh2)
            w_seq_last = 3'd5;
        else if (r_sw2 || r_sh2)
            w_seq_last = 3'd3;
        else
            w_seq_last = 3'd2;
        w_cap_ok  = (r_outst < OUT_MAX);
        w_grant   = (r_state == S_RUN) && BlockReq && !DataInFull && w_cap_ok && !BlockAck;
        w_done_ok = BlockDone && (r_outst != 3'd0);
        w_x_last  = (r_x == McuBlockWidth - 12'd1);
        w_last    = w_x_last && (r_y == r_rows - 12'd1) && (r_seq == w_seq_last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cfg_ok      <= 1'b0;
            r_gray        <= 1'b0;
            r_sw2         <= 1'b0;
            r_sh2         <= 1'b0;
            r_width       <= '0;
            r_height      <= '0;
            r_rows        <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_seq         <= '0;
            r_outst       <= '0;
            BlockAck      <= 1'b0;
            BlockColor    <= '0;
            McuX          <= '0;
            McuY          <= '0;
            McuBlockWidth <= '0;
            Busy          <= 1'b0;
            FrameEnd      <= 1'b0;
            ConfigError   <= 1'b0;
            SeqError      <= 1'b0;
`ifdef AQ_DJPEG_MCU_SCHED_PERF_EN
            StallCycles   <= '0;
`endif
        end else if (ProcessInit) begin
            // Abort wins over everything; a BlockDone this cycle belongs to the discarded frame
            r_state     <= S_CONFIG;
            r_cfg_ok    <= w_cfg_ok;
            r_gray      <= (JpegComp == 3'd1);
            r_sw2       <= (JpegComp != 3'd1) && (SubSamplingW == 2'd2);
            r_sh2       <= (JpegComp != 3'd1) && (SubSamplingH == 2'd2);
            r_width     <= ImageWidth;
            r_height    <= ImageHeight;
            r_x         <= '0;
            r_y         <= '0;
            r_seq       <= '0;
            r_outst     <= '0;
            BlockAck    <= 1'b0;
            Busy        <= w_cfg_ok;
            FrameEnd    <= 1'b0;
            ConfigError <= 1'b0;
            SeqError    <= 1'b0;
`ifdef AQ_DJPEG_MCU_SCHED_PERF_EN
            StallCycles <= '0;
`endif
        end else begin
            BlockAck <= w_grant;
            FrameEnd <= 1'b0;

            if (w_grant && !w_done_ok)
                r_outst <= r_outst + 3'd1;
            else if (!w_grant && w_done_ok)
                r_outst <= r_outst - 3'd1;

            if (BlockDone && (r_outst == 3'd0))
                SeqError <= 1'b1;
            if (BlockReq && ((r_state == S_IDLE) || (r_state == S_DONE)))
                SeqError <= 1'b1;

`ifdef AQ_DJPEG_MCU_SCHED_PERF_EN
            if ((r_state == S_RUN) && BlockReq && !w_grant && (DataInFull || !w_cap_ok) &&
                (StallCycles != '1))
                StallCycles <= StallCycles + 32'd1;
`endif

            unique case (r_state)
                S_CONFIG: begin
                    if (!r_cfg_ok) begin
                        ConfigError <= 1'b1;
                        Busy        <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        McuBlockWidth <= w_mcu_cols;
                        r_rows        <= w_mcu_rows;
                        r_x           <= '0;
                        r_y           <= '0;
                        r_seq         <= '0;
                        r_state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_grant) begin
                        BlockColor <= seq_color(r_gray, r_sw2, r_sh2, r_seq);
                        McuX       <= r_x;
                        McuY       <= r_y;
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end else if (r_seq == w_seq_last) begin
                            r_seq <= '0;
                            if (w_x_last) begin
                                r_x <= '0;
                                r_y <= r_y + 12'd1;
                            end else begin
                                r_x <= r_x + 12'd1;
                            end
                        end else begin
                            r_seq <= r_seq + 3'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_outst == 3'd0) begin
                        FrameEnd <= 1'b1;
                        Busy     <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aq_djpeg_mcu_sched.sv
// Directed self-checking bench for aq_djpeg_mcu_sched (default cap of 2 outstanding blocks).
module tb_aq_djpeg_mcu_sched;

    logic        rst;
    logic        clk;
    logic        ProcessInit;
    logic [2:0]  JpegComp;
    logic [1:0]  SubSamplingW;
    logic [1:0]  SubSamplingH;
    logic [15:0] ImageWidth;
    logic [15:0] ImageHeight;
    logic        BlockReq;
    logic        BlockAck;
    logic [2:0]  BlockColor;
    logic [11:0] McuX;
    logic [11:0] McuY;
    logic [11:0] McuBlockWidth;
    logic        BlockDone;
    logic        DataInFull;
    logic        Busy;
    logic        FrameEnd;
    logic        ConfigError;
    logic        SeqError;
`ifdef AQ_DJPEG_MCU_SCHED_PERF_EN
    logic [31:0] StallCycles;
`endif

    aq_djpeg_mcu_sched #(.MAX_OUTSTANDING(2)) dut (
        .rst           (rst),
        .clk           (clk),
        .ProcessInit   (ProcessInit),
        .JpegComp      (JpegComp),
        .SubSamplingW  (SubSamplingW),
        .SubSamplingH  (SubSamplingH),
        .ImageWidth    (ImageWidth),
        .ImageHeight   (ImageHeight),
        .BlockReq      (BlockReq),
        .BlockAck      (BlockAck),
        .BlockColor    (BlockColor),
        .McuX          (McuX),
        .McuY          (McuY),
        .McuBlockWidth (McuBlockWidth),
        .BlockDone     (BlockDone),
        .DataInFull    (DataInFull),
        .Busy          (Busy),
        .FrameEnd      (FrameEnd),
        .ConfigError   (ConfigError),
        .SeqError      (SeqError)
`ifdef AQ_DJPEG_MCU_SCHED_PERF_EN
        ,
        .StallCycles   (StallCycles)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [26:0] g_tag[$];
    int          fe_cnt = 0;
    logic [26:0] exp_q[$];

    logic auto_done = 1'b1;
    logic auto_pulse = 1'b0;
    logic man_done = 1'b0;

    assign BlockDone = auto_pulse | man_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Grant/FrameEnd monitor
    initial forever begin
        @(negedge clk);
        if (BlockAck)
            g_tag.push_back({BlockColor, McuX, McuY});
        if (FrameEnd)
            fe_cnt++;
    end

    // Instant-completion responder: BlockDone the cycle after each grant
    initial forever begin
        @(negedge clk);
        auto_pulse = auto_done && BlockAck;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_frame(input logic [2:0] comp, input logic [1:0] sw, input logic [1:0] sh,
                               input logic [15:0] w, input logic [15:0] h);
        JpegComp     = comp;
        SubSamplingW = sw;
        SubSamplingH = sh;
        ImageWidth   = w;
        ImageHeight  = h;
        ProcessInit  = 1'b1;
        @(negedge clk);
        ProcessInit  = 1'b0;
    endtask

    task automatic wait_fe(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (FrameEnd) begin
                seen = 1'b1;
                break;
            end
        end
        BlockReq = 1'b0;
        chk({tag, "_frameend_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_tags(input string tag, input int base);
        chk({tag, "_grants"}, 32'(g_tag.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < g_tag.size())
                chk($sformatf("%s_tag%0d", tag, i), 32'(g_tag[base + i]), 32'(exp_q[i]));
        end
    endtask

    function automatic logic [26:0] mk(input int c, input int x, input int y);
        return {3'(c), 12'(x), 12'(y)};
    endfunction

    initial begin
        int base;
        int fe_base;
        int k;
        int acks;
        int seq444[3];
        int seq422[4];
        int seq440[4];
        seq444 = '{0, 4, 5};
        seq422 = '{0, 1, 4, 5};
        seq440 = '{0, 2, 4, 5};

        rst = 1'b0;
        ProcessInit = 1'b0;
        JpegComp = '0;
        SubSamplingW = '0;
        SubSamplingH = '0;
        ImageWidth = '0;
        ImageHeight = '0;
        BlockReq = 1'b0;
        DataInFull = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(BlockAck), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_frameend", 32'(FrameEnd), 32'd0);
        chk("rst_errs", 32'({ConfigError, SeqError}), 32'd0);
        chk("rst_tag", 32'({BlockColor, McuX, McuY, McuBlockWidth}), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 4:2:0, 32x16 -> 2x1 MCUs
        base = g_tag.size();
        fe_base = fe_cnt;
        start_frame(3'd3, 2'd2, 2'd2, 16'd32, 16'd16);
        chk("420_busy_config", 32'(Busy), 32'd1);
        BlockReq = 1'b1;
        wait_fe("420");
        chk("420_busy_after", 32'(Busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("420_mcuw", 32'(McuBlockWidth), 32'd2);
        chk("420_fe_once", 32'(fe_cnt - fe_base), 32'd1);
        chk("420_seqerr", 32'(SeqError), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(mk(i % 6, i / 6, 0));
        check_tags("420", base);

        // Grayscale 17x9 -> 3x2 MCUs; subsampling inputs ignored
        base = g_tag.size();
        fe_base = fe_cnt;
        start_frame(3'd1, 2'd2, 2'd2, 16'd17, 16'd9);
        BlockReq = 1'b1;
        wait_fe("gray");
        repeat (5) @(negedge clk);
        chk("gray_mcuw", 32'(McuBlockWidth), 32'd3);
        chk("gray_fe_once", 32'(fe_cnt - fe_base), 32'd1);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(mk(0, i % 3, i / 3));
        check_tags("gray", base);

        // 4:2:2 and 4:4:0 single-MCU frames
        base = g_tag.size();
        start_frame(3'd3, 2'd2, 2'd1, 16'd16, 16'd8);
        BlockReq = 1'b1;
        wait_fe("422");
        repeat (3) @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(seq422[i], 0, 0));
        check_tags("422", base);

        base = g_tag.size();
        start_frame(3'd3, 2'd1, 2'd2, 16'd8, 16'd16);
        BlockReq = 1'b1;
        wait_fe("440");
        repeat (3) @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(seq440[i], 0, 0));
        check_tags("440", base);

        // Backpressure: 4:4:4 64x8 (8x1 MCUs, 24 blocks), 20-cycle DataInFull after 4th grant
        base = g_tag.size();
        start_frame(3'd3, 2'd1, 2'd1, 16'd64, 16'd8);
        BlockReq = 1'b1;
        k = 0;
        for (int i = 0; i < 100 && k < 4; i++) begin
            @(negedge clk);
            if (BlockAck) k++;
        end
        chk("bp_reach4", 32'(k), 32'd4);
        DataInFull = 1'b1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (BlockAck) acks++;
        end
        chk("bp_no_ack_stall", 32'(acks), 32'd0);
`ifdef AQ_DJPEG_MCU_SCHED_PERF_EN
        chk("bp_stallcycles", StallCycles, 32'd20);
`endif
        DataInFull = 1'b0;
        @(negedge clk);
        chk("bp_resume", 32'(BlockAck), 32'd1);
        chk("bp_resume_tag", 32'({BlockColor, McuX, McuY}), 32'(mk(4, 1, 0)));
        wait_fe("bp");
        repeat (3) @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < 24; i++) exp_q.push_back(mk(seq444[i % 3], i / 3, 0));
        check_tags("bp", base);

        // Abort after 5 grants of a 4:4:4 frame, then run the restart to completion
        fe_base = fe_cnt;
        start_frame(3'd3, 2'd1, 2'd1, 16'd64, 16'd8);
        BlockReq = 1'b1;
        k = 0;
        for (int i = 0; i < 100 && k < 5; i++) begin
            @(negedge clk);
            if (BlockAck) k++;
        end
        chk("abort_reach5", 32'(k), 32'd5);
        ProcessInit = 1'b1;
        @(negedge clk);
        ProcessInit = 1'b0;
        base = g_tag.size();
        chk("abort_busy", 32'(Busy), 32'd1);
        chk("abort_ack_config", 32'(BlockAck), 32'd0);
        @(negedge clk);
        chk("abort_ack_run", 32'(BlockAck), 32'd0);
        @(negedge clk);
        chk("abort_first_ack", 32'(BlockAck), 32'd1);
        chk("abort_first_tag", 32'({BlockColor, McuX, McuY}), 32'(mk(0, 0, 0)));
        wait_fe("abort");
        repeat (3) @(negedge clk);
        chk("abort_fe_once", 32'(fe_cnt - fe_base), 32'd1);
        chk("abort_seqerr", 32'(SeqError), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 24; i++) exp_q.push_back(mk(seq444[i % 3], i / 3, 0));
        check_tags("abort", base);

        // Illegal component count
        start_frame(3'd2, 2'd1, 2'd1, 16'd16, 16'd16);
        chk("cfg1_busy_n1", 32'(Busy), 32'd0);
        @(negedge clk);
        chk("cfg1_err", 32'(ConfigError), 32'd1);
        chk("cfg1_busy_n2", 32'(Busy), 32'd0);
        chk("cfg1_seqerr_clr", 32'(SeqError), 32'd0);
        BlockReq = 1'b1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (BlockAck) acks++;
        end
        BlockReq = 1'b0;
        chk("cfg1_no_ack", 32'(acks), 32'd0);
        chk("cfg1_seqerr", 32'(SeqError), 32'd1);

        // Zero width; ProcessInit also clears the sticky SeqError
        start_frame(3'd3, 2'd1, 2'd1, 16'd0, 16'd16);
        chk("cfg2_seqerr_clr", 32'(SeqError), 32'd0);
        @(negedge clk);
        chk("cfg2_err", 32'(ConfigError), 32'd1);
        chk("cfg2_busy", 32'(Busy), 32'd0);

        // Outstanding cap with BlockDone withheld
        auto_done = 1'b0;
        base = g_tag.size();
        start_frame(3'd3, 2'd1, 2'd1, 16'd64, 16'd8);
        chk("cap_cfgerr_clr", 32'(ConfigError), 32'd0);
        BlockReq = 1'b1;
        repeat (20) @(negedge clk);
        chk("cap_two_grants", 32'(g_tag.size() - base), 32'd2);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (10) @(negedge clk);
        chk("cap_one_more", 32'(g_tag.size() - base), 32'd3);
        chk("cap_third_tag", 32'(g_tag[base + 2]), 32'(mk(5, 0, 0)));
        chk("cap_seqerr", 32'(SeqError), 32'd0);
        BlockReq = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
